// File: rtl/multiplexer_n_to_1_registered_if.sv
// Handshake bundle for the registered N-to-1 selector: per-channel requests in,
// one registered word out.
interface multiplexer_n_to_1_registered_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

    logic                   mode;
    logic [SELW-1:0]        sel;
    logic [N-1:0]           in_valid;
    logic [N*WIDTH-1:0]     in_data;
    logic [N-1:0]           in_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [SELW-1:0]        out_sel;
    logic                   out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/multiplexer_n_to_1_registered.sv
// N-to-1 WIDTH-bit selector with one registered output stage; fixed-select or
// round-robin grant, valid/ready on every channel, full throughput.
module multiplexer_n_to_1_registered #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    multiplexer_n_to_1_registered_if.slave bus
);
    localparam int unsigned     SELW = (N > 1) ? $clog2(N) : 1;
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic                   out_valid_q;
    logic [WIDTH-1:0]       out_data_q;
    logic [SELW-1:0]        out_sel_q;
    logic [SELW-1:0]        rr_ptr;

    logic                   load;
    logic                   gnt_v;
    logic [SELW-1:0]        gnt;
    logic [SELW-1:0]        rr_next;
    logic [WIDTH-1:0]       gnt_data;
    logic [N-1:0]           ready;
    int unsigned            idx;

    assign load = !out_valid_q || bus.out_ready;

    // Grant: explicit select, or first requester at/after rr_ptr (scanned in
    // reverse so the nearest offset is the last and winning assignment).
    always_comb begin
        gnt   = '0;
        gnt_v = 1'b0;
        idx   = 0;
        if (!bus.mode) begin
            gnt = bus.sel;
            if (32'(bus.sel) < N) begin
                gnt_v = bus.in_valid[bus.sel];
            end
        end else begin
            gnt_v = |bus.in_valid;
            for (int k = int'(N) - 1; k >= 0; k--) begin
                idx = 32'(rr_ptr) + 32'(k);
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (bus.in_valid[SELW'(idx)]) begin
                    gnt = SELW'(idx);
                end
            end
        end
    end

    // Data steering and per-channel accept.
    always_comb begin
        gnt_data = '0;
        ready    = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt == SELW'(i)) begin
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
                ready[i] = !rst && load && gnt_v;
            end
        end
    end

    // Explicit wrap so non-power-of-2 N never relies on SELW overflow.
    assign rr_next = (gnt == LAST) ? '0 : gnt + SELW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            if (gnt_v) begin
                out_valid_q <= 1'b1;
                out_data_q  <= gnt_data;
                out_sel_q   <= gnt;
                if (bus.mode) begin
                    rr_ptr <= rr_next;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule
